// File: rtl/pacman_mover.sv
// pacman_mover: frame-paced sprite mover. Each frame tick may query the
// wall map (turn target, then forward tile) and advances the sprite by
// STEP pixels, with vertical clamping and optional horizontal tunnel wrap.
module pacman_mover #(
    parameter int TILE    = 16,
    parameter int STEP    = 2,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479,
    parameter int X_START = 160,
    parameter int Y_START = 240,
    parameter int WRAP    = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic       wall_req,
    output logic [5:0] wall_tx,
    output logic [5:0] wall_ty,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] dir,
    output logic       moving,
    output logic       overrun
);

    localparam int TSH = $clog2(TILE);
    localparam logic [9:0] TMASK = 10'(TILE - 1);
    localparam logic signed [10:0] STEP_S    = 11'(STEP);
    localparam logic signed [10:0] XMIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S    = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S    = 11'(Y_MAX);
    localparam logic signed [10:0] XWRAP_R_S = 11'(X_MAX - TILE + 1);
    localparam logic signed [10:0] XWRAP_L_S = 11'(((X_MAX - TILE + 1) / TILE) * TILE);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        Q_TURN = 2'b01,
        Q_FWD  = 2'b10,
        MOVE   = 2'b11
    } state_t;

    state_t      state_q;
    logic [9:0]  pos_x_q, pos_y_q;
    logic [1:0]  dir_q, pending_q, turn_dir_q;
    logic        moving_q, overrun_q, wall_req_q;
    logic [5:0]  wall_tx_q, wall_ty_q;

    logic        key_vld_s;
    logic [1:0]  key_dir_s;
    logic [1:0]  eff_dir_s, turn_res_s;
    logic        aligned_s;
    logic [11:0] q_pend_s, q_eff_s, q_turn_s;
    logic signed [10:0] sx_s, sy_s, nx_s, ny_s;
    logic [9:0]  pos_x_d, pos_y_d;
    logic        move_ok_d;

    // Tile coordinates (modulo 64) of the neighbour of (x,y) in direction d.
    function automatic logic [11:0] tile_adj(input logic [1:0] d,
                                             input logic [9:0] x,
                                             input logic [9:0] y);
        logic [5:0] tx;
        logic [5:0] ty;
        tx = 6'(x >> TSH);
        ty = 6'(y >> TSH);
        case (d)
            DIR_UP:   ty = ty - 6'd1;
            DIR_DOWN: ty = ty + 6'd1;
            DIR_LEFT: tx = tx - 6'd1;
            default:  tx = tx + 6'd1;
        endcase
        return {tx, ty};
    endfunction

    // Decode the WASD keycodes; anything else is not a direction.
    always_comb begin
        key_vld_s = 1'b1;
        key_dir_s = DIR_LEFT;
        case (keycode)
            8'h1A:   key_dir_s = DIR_UP;
            8'h16:   key_dir_s = DIR_DOWN;
            8'h04:   key_dir_s = DIR_LEFT;
            8'h07:   key_dir_s = DIR_RIGHT;
            default: key_vld_s = 1'b0;
        endcase
    end

    // Direction after an instant reversal, alignment and the three query targets.
    always_comb begin
        eff_dir_s  = (pending_q == (dir_q ^ 2'b01)) ? pending_q : dir_q;
        turn_res_s = wall_hit ? dir_q : turn_dir_q;
        aligned_s  = ((pos_x_q & TMASK) == 10'd0) && ((pos_y_q & TMASK) == 10'd0);
        q_pend_s   = tile_adj(pending_q, pos_x_q, pos_y_q);
        q_eff_s    = tile_adj(eff_dir_s, pos_x_q, pos_y_q);
        q_turn_s   = tile_adj(turn_res_s, pos_x_q, pos_y_q);
    end

    // One step along dir in signed arithmetic, then clamp or wrap at the edges.
    always_comb begin
        sx_s      = $signed({1'b0, pos_x_q});
        sy_s      = $signed({1'b0, pos_y_q});
        move_ok_d = 1'b1;
        case (dir_q)
            DIR_UP:   sy_s = sy_s - STEP_S;
            DIR_DOWN: sy_s = sy_s + STEP_S;
            DIR_LEFT: sx_s = sx_s - STEP_S;
            default:  sx_s = sx_s + STEP_S;
        endcase
        if (sy_s < YMIN_S) begin
            ny_s      = YMIN_S;
            move_ok_d = 1'b0;
        end else if (sy_s > YMAX_S) begin
            ny_s      = YMAX_S;
            move_ok_d = 1'b0;
        end else begin
            ny_s = sy_s;
        end
        if (WRAP != 0) begin
            if (sx_s < XMIN_S) begin
                nx_s = XWRAP_L_S;
            end else if (sx_s > XWRAP_R_S) begin
                nx_s = XMIN_S;
            end else begin
                nx_s = sx_s;
            end
        end else begin
            if (sx_s < XMIN_S) begin
                nx_s      = XMIN_S;
                move_ok_d = 1'b0;
            end else if (sx_s > XMAX_S) begin
                nx_s      = XMAX_S;
                move_ok_d = 1'b0;
            end else begin
                nx_s = sx_s;
            end
        end
        pos_x_d = 10'(nx_s);
        pos_y_d = 10'(ny_s);
    end

    // Movement FSM with keycode latch, wall-map handshake and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            pos_x_q    <= 10'(X_START);
            pos_y_q    <= 10'(Y_START);
            dir_q      <= DIR_LEFT;
            pending_q  <= DIR_LEFT;
            turn_dir_q <= DIR_LEFT;
            moving_q   <= 1'b0;
            overrun_q  <= 1'b0;
            wall_req_q <= 1'b0;
            wall_tx_q  <= 6'd0;
            wall_ty_q  <= 6'd0;
        end else begin
            if (key_vld_s) begin
                pending_q <= key_dir_s;
            end
            if (frame_tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        dir_q <= eff_dir_s;
                        if (!aligned_s) begin
                            state_q <= MOVE;
                        end else if (pending_q != eff_dir_s) begin
                            state_q                <= Q_TURN;
                            turn_dir_q             <= pending_q;
                            wall_req_q             <= 1'b1;
                            {wall_tx_q, wall_ty_q} <= q_pend_s;
                        end else begin
                            state_q                <= Q_FWD;
                            wall_req_q             <= 1'b1;
                            {wall_tx_q, wall_ty_q} <= q_eff_s;
                        end
                    end
                end
                Q_TURN: begin
                    if (wall_ack) begin
                        dir_q                  <= turn_res_s;
                        state_q                <= Q_FWD;
                        {wall_tx_q, wall_ty_q} <= q_turn_s;
                    end
                end
                Q_FWD: begin
                    if (wall_ack) begin
                        wall_req_q <= 1'b0;
                        if (wall_hit) begin
                            moving_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    pos_x_q  <= pos_x_d;
                    pos_y_q  <= pos_y_d;
                    moving_q <= move_ok_d;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    wall_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign wall_req = wall_req_q;
    assign wall_tx  = wall_tx_q;
    assign wall_ty  = wall_ty_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign dir      = dir_q;
    assign moving   = moving_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: directed scenarios plus a randomized walk checked
// against a pixel/tile-level behavioural model of the mover.
module tb_pacman_mover;

    localparam int TILE = 16, STEP = 2, X_MIN = 0, X_MAX = 639, Y_MIN = 0, Y_MAX = 479, WRAP = 1;

    logic       Clk = 1'b0, Reset_n = 1'b1, frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       wall_ack = 1'b0, wall_hit = 1'b0;
    logic       wall_req, moving, overrun;
    logic [5:0] wall_tx, wall_ty;
    logic [9:0] pos_x, pos_y;
    logic [1:0] dir;

    pacman_mover #(.TILE(TILE), .STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN),
                   .Y_MAX(Y_MAX), .X_START(160), .Y_START(240), .WRAP(WRAP)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
        .wall_req(wall_req), .wall_tx(wall_tx), .wall_ty(wall_ty), .wall_ack(wall_ack),
        .wall_hit(wall_hit), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
        .overrun(overrun));

    always #5 Clk = ~Clk;

    int n_total = 0, n_bad = 0;

    // observations from the wall-map responder
    int obs_nq, obs_qx[2], obs_qy[2];
    bit obs_unstable;

    // behavioural model state
    int m_x, m_y, m_nq, m_qx[2], m_qy[2];
    logic [1:0] m_dir, m_pend;
    bit m_mov;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset;
        Reset_n = 1'b0; frame_tick = 1'b0; wall_ack = 1'b0; wall_hit = 1'b0; keycode = 8'h00;
        #12;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cyc(1);
    endtask

    // Pulse a tick, then answer up to two wall queries with the given hits.
    task automatic drive_frame(input bit h0, input bit h1, input logic [7:0] k2);
        bit hits[2];
        int c, lat;
        hits[0] = h0; hits[1] = h1;
        obs_nq = 0; obs_unstable = 1'b0;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        keycode = k2;
        for (int k = 0; k < 2; k++) begin
            c = 0;
            while (!wall_req && c < 6) begin
                cyc(1);
                c++;
            end
            if (!wall_req) break;
            obs_qx[k] = wall_tx; obs_qy[k] = wall_ty; obs_nq++;
            lat = $urandom_range(0, 2);
            for (int l = 0; l < lat; l++) begin
                cyc(1);
                if (!wall_req || wall_tx != obs_qx[k] || wall_ty != obs_qy[k]) obs_unstable = 1'b1;
            end
            wall_ack = 1'b1; wall_hit = hits[k];
            cyc(1);
            wall_ack = 1'b0; wall_hit = 1'($urandom_range(0, 1));
        end
        cyc(3);
    endtask

    function automatic int dxf(input logic [1:0] d);
        return (d == 2'd2) ? -1 : (d == 2'd3) ? 1 : 0;
    endfunction

    function automatic int dyf(input logic [1:0] d);
        return (d == 2'd0) ? -1 : (d == 2'd1) ? 1 : 0;
    endfunction

    function automatic int tadj(input int p, input int d);
        return (((p / TILE) + d) % 64 + 64) % 64;
    endfunction

    task automatic model_key(input logic [7:0] k);
        case (k)
            8'h1A:   m_pend = 2'd0;
            8'h16:   m_pend = 2'd1;
            8'h04:   m_pend = 2'd2;
            8'h07:   m_pend = 2'd3;
            default: ;
        endcase
    endtask

    task automatic model_frame(input bit h0, input bit h1);
        bit hits[2];
        int hi, nx, ny;
        hits[0] = h0; hits[1] = h1; hi = 0; m_nq = 0;
        if (m_pend == (m_dir ^ 2'd1)) m_dir = m_pend;
        if ((m_x % TILE == 0) && (m_y % TILE == 0)) begin
            if (m_pend != m_dir) begin
                m_qx[m_nq] = tadj(m_x, dxf(m_pend)); m_qy[m_nq] = tadj(m_y, dyf(m_pend)); m_nq++;
                if (!hits[hi]) m_dir = m_pend;
                hi++;
            end
            m_qx[m_nq] = tadj(m_x, dxf(m_dir)); m_qy[m_nq] = tadj(m_y, dyf(m_dir)); m_nq++;
            if (hits[hi]) begin
                m_mov = 1'b0;
                return;
            end
        end
        nx = m_x + STEP * dxf(m_dir);
        ny = m_y + STEP * dyf(m_dir);
        m_mov = 1'b1;
        if (ny < Y_MIN) begin ny = Y_MIN; m_mov = 1'b0; end
        else if (ny > Y_MAX) begin ny = Y_MAX; m_mov = 1'b0; end
        if (nx < X_MIN) nx = ((X_MAX - TILE + 1) / TILE) * TILE;
        else if (nx > X_MAX - TILE + 1) nx = X_MIN;
        m_x = nx; m_y = ny;
    endtask

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 6))
            0: return 8'h1A;
            1: return 8'h16;
            2: return 8'h04;
            3: return 8'h07;
            4: return 8'h00;
            5: return 8'($urandom);
            default: return 8'h2C;
        endcase
    endfunction

    task automatic test_reset;
        Reset_n = 1'b0;
        #3;
        n_total++; if (pos_x !== 10'd160) begin n_bad++; $display("FAIL reset_pos_x: got %0d want 160", pos_x); end
        n_total++; if (pos_y !== 10'd240) begin n_bad++; $display("FAIL reset_pos_y: got %0d want 240", pos_y); end
        n_total++; if (dir !== 2'b10) begin n_bad++; $display("FAIL reset_dir: got %0d want 2", dir); end
        n_total++; if ({wall_req, moving, overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {wall_req, moving, overrun}); end
        n_total++; if ({wall_tx, wall_ty} !== 12'd0) begin n_bad++; $display("FAIL reset_tile: got %0d,%0d want 0,0", wall_tx, wall_ty); end
        do_reset;
    endtask

    task automatic test_straight;
        do_reset;
        drive_frame(1'b0, 1'b0, 8'h00);
        n_total++; if (obs_nq != 1 || obs_qx[0] != 9 || obs_qy[0] != 15) begin n_bad++; $display("FAIL straight_query: got n=%0d (%0d,%0d) want n=1 (9,15)", obs_nq, obs_qx[0], obs_qy[0]); end
        n_total++; if (pos_x !== 10'd158 || pos_y !== 10'd240) begin n_bad++; $display("FAIL straight_pos: got %0d,%0d want 158,240", pos_x, pos_y); end
        n_total++; if (moving !== 1'b1 || dir !== 2'b10) begin n_bad++; $display("FAIL straight_state: got mv=%0d dir=%0d want mv=1 dir=2", moving, dir); end
    endtask

    task automatic test_turn;
        do_reset;
        keycode = 8'h1A;
        cyc(1);
        drive_frame(1'b0, 1'b0, 8'h1A);
        n_total++; if (obs_nq != 2 || obs_qx[0] != 10 || obs_qy[0] != 14 || obs_qx[1] != 10 || obs_qy[1] != 14) begin n_bad++; $display("FAIL turn_query: got n=%0d (%0d,%0d)(%0d,%0d) want 2 (10,14)(10,14)", obs_nq, obs_qx[0], obs_qy[0], obs_qx[1], obs_qy[1]); end
        n_total++; if (dir !== 2'b00 || pos_y !== 10'd238 || pos_x !== 10'd160) begin n_bad++; $display("FAIL turn_move: got dir=%0d pos=%0d,%0d want 0 160,238", dir, pos_x, pos_y); end
    endtask

    task automatic test_fwd_hit;
        do_reset;
        keycode = 8'h04;
        cyc(1);
        for (int f = 0; f < 8; f++) drive_frame(1'b0, 1'b0, 8'h04);
        n_total++; if (pos_x !== 10'd144 || moving !== 1'b1) begin n_bad++; $display("FAIL walk_pos: got %0d mv=%0d want 144 mv=1", pos_x, moving); end
        drive_frame(1'b1, 1'b0, 8'h04);
        n_total++; if (obs_nq != 1 || obs_qx[0] != 8 || obs_qy[0] != 15) begin n_bad++; $display("FAIL hit_query: got n=%0d (%0d,%0d) want 1 (8,15)", obs_nq, obs_qx[0], obs_qy[0]); end
        n_total++; if (pos_x !== 10'd144 || moving !== 1'b0 || wall_req !== 1'b0) begin n_bad++; $display("FAIL hit_state: got x=%0d mv=%0d req=%0d want 144 0 0", pos_x, moving, wall_req); end
    endtask

    task automatic test_reverse;
        do_reset;
        drive_frame(1'b0, 1'b0, 8'h07);
        cyc(1);
        drive_frame(1'b0, 1'b0, 8'h07);
        n_total++; if (obs_nq != 0) begin n_bad++; $display("FAIL reverse_noquery: got n=%0d want 0", obs_nq); end
        n_total++; if (dir !== 2'b11 || pos_x !== 10'd160 || moving !== 1'b1) begin n_bad++; $display("FAIL reverse_state: got dir=%0d x=%0d mv=%0d want 3 160 1", dir, pos_x, moving); end
    endtask

    task automatic test_wrap;
        do_reset;
        keycode = 8'h04;
        cyc(1);
        for (int f = 0; f < 80; f++) drive_frame(1'b0, 1'b0, 8'h04);
        n_total++; if (pos_x !== 10'd0) begin n_bad++; $display("FAIL wrap_reach: got %0d want 0", pos_x); end
        drive_frame(1'b0, 1'b0, 8'h04);
        n_total++; if (obs_nq != 1 || obs_qx[0] != 63 || obs_qy[0] != 15) begin n_bad++; $display("FAIL wrap_query: got n=%0d (%0d,%0d) want 1 (63,15)", obs_nq, obs_qx[0], obs_qy[0]); end
        n_total++; if (pos_x !== 10'd624 || pos_y !== 10'd240 || moving !== 1'b1) begin n_bad++; $display("FAIL wrap_pos: got %0d,%0d mv=%0d want 624,240 1", pos_x, pos_y, moving); end
    endtask

    task automatic test_overrun_reset;
        do_reset;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        n_total++; if (wall_req !== 1'b1) begin n_bad++; $display("FAIL ovr_req: got %0d want 1", wall_req); end
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        n_total++; if (overrun !== 1'b1 || wall_req !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got ovr=%0d req=%0d want 1 1", overrun, wall_req); end
        wall_ack = 1'b1; wall_hit = 1'b0;
        cyc(1);
        wall_ack = 1'b0;
        cyc(8);
        n_total++; if (pos_x !== 10'd158 || overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_one_move: got x=%0d ovr=%0d want 158 1", pos_x, overrun); end
        do_reset;
        n_total++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %0d want 0", overrun); end
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        #3;
        Reset_n = 1'b0;
        #1;
        n_total++; if (wall_req !== 1'b0 || pos_x !== 10'd160 || dir !== 2'b10 || {wall_tx, wall_ty} !== 12'd0) begin n_bad++; $display("FAIL midq_reset: got req=%0d x=%0d dir=%0d tile=%0d,%0d want 0 160 2 0,0", wall_req, pos_x, dir, wall_tx, wall_ty); end
        #1;
        Reset_n = 1'b1;
        cyc(1);
        wall_ack = 1'b1; wall_hit = 1'b0;
        cyc(1);
        wall_ack = 1'b0;
        cyc(4);
        n_total++; if (wall_req !== 1'b0 || pos_x !== 10'd160 || moving !== 1'b0) begin n_bad++; $display("FAIL stale_ack: got req=%0d x=%0d mv=%0d want 0 160 0", wall_req, pos_x, moving); end
    endtask

    task automatic test_random;
        logic [7:0] k1, k2;
        bit h0, h1;
        do_reset;
        m_x = 160; m_y = 240; m_dir = 2'd2; m_pend = 2'd2; m_mov = 1'b0;
        for (int f = 0; f < 60; f++) begin
            k1 = pick_key();
            keycode = k1;
            model_key(k1);
            cyc(1);
            h0 = ($urandom_range(0, 3) == 0);
            h1 = ($urandom_range(0, 3) == 0);
            k2 = pick_key();
            drive_frame(h0, h1, k2);
            model_frame(h0, h1);
            model_key(k2);
            n_total++; if (obs_nq != m_nq) begin n_bad++; $display("FAIL rnd_nq f=%0d: got %0d want %0d", f, obs_nq, m_nq); end
            for (int i = 0; i < m_nq && i < obs_nq; i++) begin
                n_total++; if (obs_qx[i] != m_qx[i] || obs_qy[i] != m_qy[i]) begin n_bad++; $display("FAIL rnd_query f=%0d q%0d: got (%0d,%0d) want (%0d,%0d)", f, i, obs_qx[i], obs_qy[i], m_qx[i], m_qy[i]); end
            end
            n_total++; if (pos_x != m_x || pos_y != m_y) begin n_bad++; $display("FAIL rnd_pos f=%0d: got %0d,%0d want %0d,%0d", f, pos_x, pos_y, m_x, m_y); end
            n_total++; if (dir !== m_dir || moving !== m_mov) begin n_bad++; $display("FAIL rnd_state f=%0d: got dir=%0d mv=%0d want %0d %0d", f, dir, moving, m_dir, m_mov); end
            n_total++; if (overrun !== 1'b0 || obs_unstable) begin n_bad++; $display("FAIL rnd_handshake f=%0d: got ovr=%0d unstable=%0d want 0 0", f, overrun, obs_unstable); end
        end
    endtask

    initial begin
        test_reset;
        test_straight;
        test_turn;
        test_fwd_hit;
        test_reverse;
        test_wrap;
        test_overrun_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
